i2s_top_tx: RTL and testbench

I2S_TOP_TX -- requirements
Module: i2s_top_tx

---
 rtl/i2s_top_tx.sv | 119 +++++++++++
 tb/tb_i2s_top_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_top_tx.sv
// I2S master transmitter: divides clk_i into sclk_o and serialises a left and a
// right holding register, MSB first, with word select leading the data by one bit.
module i2s_top_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int SCLK_DIV   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  lr_chnl_i,
    input  logic                  write_i,
    output logic [1:0]            full_o,
    output logic                  ovf_o,
    output logic                  unf_o,
    output logic                  sclk_o,
    output logic                  wsel_o,
    output logic                  sdat_o
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int POS_W = (DATA_WIDTH > 1) ? $clog2(2 * DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(2 * DATA_WIDTH - 1);
    localparam logic [POS_W-1:0] POS_RIGHT = POS_W'(DATA_WIDTH);
    localparam logic [POS_W-1:0] WS_RISE   = POS_W'(DATA_WIDTH - 1);

    logic [DIV_W-1:0]                 div_q, div_d;
    logic                             sclk_q, sclk_d;
    logic [POS_W-1:0]                 pos_q, pos_d;
    logic                             wsel_q, wsel_d;
    logic [DATA_WIDTH-1:0]            shift_q, shift_d;
    logic [1:0][DATA_WIDTH-1:0]       hold_q, hold_d;
    logic [1:0]                       full_q, full_d;
    logic                             ovf_q, ovf_d;
    logic                             unf_q, unf_d;

    logic                             fall;
    logic                             load_any;
    logic                             load_ch;

    always_comb begin
        div_d    = div_q;
        sclk_d   = sclk_q;
        pos_d    = pos_q;
        wsel_d   = wsel_q;
        shift_d  = shift_q;
        hold_d   = hold_q;
        full_d   = full_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        fall     = 1'b0;
        load_any = 1'b0;
        load_ch  = 1'b0;

        if (div_q == DIV_LAST) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            fall   = sclk_q;
        end else begin
            div_d = div_q + 1'b1;
        end

        // pos_q names the last falling event; reset parks it on the final slot
        // so the first event after reset lands on position 0.
        if (fall) begin
            pos_d    = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
            wsel_d   = (pos_d >= WS_RISE) && (pos_d != POS_LAST);
            load_any = (pos_d == '0) || (pos_d == POS_RIGHT);
            load_ch  = (pos_d == POS_RIGHT);
            if (load_any) begin
                shift_d         = full_q[load_ch] ? hold_q[load_ch] : '0;
                unf_d           = ~full_q[load_ch];
                full_d[load_ch] = 1'b0;
            end else begin
                shift_d = shift_q << 1;
            end
        end

        // A write in the load cycle refills the register the load just drained.
        if (write_i) begin
            hold_d[lr_chnl_i] = data_i;
            full_d[lr_chnl_i] = 1'b1;
            ovf_d             = full_q[lr_chnl_i] && !(load_any && (load_ch == lr_chnl_i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_q   <= '0;
            sclk_q  <= 1'b0;
            pos_q   <= POS_LAST;
            wsel_q  <= 1'b0;
            shift_q <= '0;
            hold_q  <= '0;
            full_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            pos_q   <= pos_d;
            wsel_q  <= wsel_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign full_o = full_q;
    assign ovf_o  = ovf_q;
    assign unf_o  = unf_q;
    assign sclk_o = sclk_q;
    assign wsel_o = wsel_q;
    assign sdat_o = shift_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_i2s_top_tx.sv
// Bench for i2s_top_tx: three instances (SCLK_DIV 2, 1, 3) share one write stream;
// every cycle is compared with a model derived from write times and load times.
module tb_i2s_top_tx;

    localparam int DW   = 16;
    localparam int MAXE = 1100;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data;
    logic          lr;
    logic          wr;
    logic [5:0]    full_w;
    logic [2:0]    ovf_w, unf_w, sclk_w, wsel_w, sdat_w;

    int checks = 0;
    int errors = 0;
    int dv [3] = '{2, 1, 3};

    bit            wr_en  [MAXE];
    bit            wr_ch  [MAXE];
    logic [DW-1:0] wr_dat [MAXE];
    logic [DW-1:0] rxw    [3][2][20];

    i2s_top_tx #(.DATA_WIDTH(DW), .SCLK_DIV(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .lr_chnl_i(lr), .write_i(wr),
        .full_o(full_w[1:0]), .ovf_o(ovf_w[0]), .unf_o(unf_w[0]),
        .sclk_o(sclk_w[0]), .wsel_o(wsel_w[0]), .sdat_o(sdat_w[0]));

    i2s_top_tx #(.DATA_WIDTH(DW), .SCLK_DIV(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .lr_chnl_i(lr), .write_i(wr),
        .full_o(full_w[3:2]), .ovf_o(ovf_w[1]), .unf_o(unf_w[1]),
        .sclk_o(sclk_w[1]), .wsel_o(wsel_w[1]), .sdat_o(sdat_w[1]));

    i2s_top_tx #(.DATA_WIDTH(DW), .SCLK_DIV(3)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .lr_chnl_i(lr), .write_i(wr),
        .full_o(full_w[5:4]), .ovf_o(ovf_w[2]), .unf_o(unf_w[2]),
        .sclk_o(sclk_w[2]), .wsel_o(wsel_w[2]), .sdat_o(sdat_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge e (counted from reset release) loads channel ch when it is a falling
    // event whose slot number is 0 (left) or 16 (right) within the 32-slot frame.
    function automatic bit is_load(int d, int ch, int e);
        if (e < 1 || (e % (2 * d)) != 0) return 1'b0;
        return (((e / (2 * d)) - 1) % 32) == 16 * ch;
    endfunction

    function automatic int last_load(int d, int ch, int e);
        for (int x = e; x >= 1; x--)
            if (is_load(d, ch, x)) return x;
        return 0;
    endfunction

    function automatic bit full_exp(int d, int ch, int e);
        int lo = last_load(d, ch, e);
        for (int w = (lo < 1) ? 1 : lo; w <= e; w++)
            if (wr_en[w] && int'(wr_ch[w]) == ch) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] word_exp(int d, int ch, int n);
        int            ld = 2 * d * (32 * n + 1 + 16 * ch);
        int            lo = (n == 0) ? 1 : 2 * d * (32 * (n - 1) + 1 + 16 * ch);
        logic [DW-1:0] v  = '0;
        for (int w = lo; w < ld && w < MAXE; w++)
            if (wr_en[w] && int'(wr_ch[w]) == ch) v = wr_dat[w];
        return v;
    endfunction

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    task automatic chk_reset(string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_sclk"}, i, 32'(sclk_w[i]), 32'd0);
            chk({tag, "_wsel"}, i, 32'(wsel_w[i]), 32'd0);
            chk({tag, "_sdat"}, i, 32'(sdat_w[i]), 32'd0);
            chk({tag, "_full"}, i, 32'(full_w[2*i +: 2]), 32'd0);
            chk({tag, "_ovf"},  i, 32'(ovf_w[i]), 32'd0);
            chk({tag, "_unf"},  i, 32'(unf_w[i]), 32'd0);
        end
    endtask

    task automatic check_cycle(int e);
        for (int i = 0; i < 3; i++) begin
            int            d = dv[i];
            int            j = e / (2 * d);
            int            p = 0;
            int            n = 0;
            bit            ovf_e, unf_e, ws_e, sd_e;
            logic [DW-1:0] w;
            ovf_e = (e >= 1) && wr_en[e] && !is_load(d, int'(wr_ch[e]), e) &&
                    full_exp(d, int'(wr_ch[e]), e - 1);
            unf_e = (e >= 1) && ((is_load(d, 0, e) && !full_exp(d, 0, e - 1)) ||
                                 (is_load(d, 1, e) && !full_exp(d, 1, e - 1)));
            ws_e = 1'b0;
            sd_e = 1'b0;
            if (j > 0) begin
                p    = (j - 1) % 32;
                n    = (j - 1) / 32;
                ws_e = !(p == 31 || p <= 14);
                w    = word_exp(d, p / 16, n);
                sd_e = w[15 - (p % 16)];
            end
            chk("sclk", i, 32'(sclk_w[i]), 32'((e / d) % 2));
            chk("full", i, 32'(full_w[2*i +: 2]), 32'({full_exp(d, 1, e), full_exp(d, 0, e)}));
            chk("ovf",  i, 32'(ovf_w[i]), 32'(ovf_e));
            chk("unf",  i, 32'(unf_w[i]), 32'(unf_e));
            chk("wsel", i, 32'(wsel_w[i]), 32'(ws_e));
            chk("sdat", i, 32'(sdat_w[i]), 32'(sd_e));
            // Receiver side: capture the bit present at each sclk rising edge.
            if ((e % (2 * d)) == d && j > 0 && n < 20)
                rxw[i][p / 16][n][15 - (p % 16)] = sdat_w[i];
        end
    endtask

    task automatic drive(int e);
        if (e < MAXE && wr_en[e]) begin
            wr   = 1'b1;
            lr   = wr_ch[e];
            data = wr_dat[e];
        end else begin
            wr   = 1'b0;
            lr   = 1'($urandom);
            data = DW'($urandom);
        end
    endtask

    task automatic gen_random(int lo, int hi, int pct);
        for (int e = lo; e <= hi && e < MAXE; e++)
            if ($urandom_range(99) < pct && !wr_en[e]) begin
                wr_en[e]  = 1'b1;
                wr_ch[e]  = 1'($urandom_range(1));
                wr_dat[e] = DW'($urandom);
            end
    endtask

    task automatic clear_writes();
        for (int e = 0; e < MAXE; e++) begin
            wr_en[e]  = 1'b0;
            wr_ch[e]  = 1'b0;
            wr_dat[e] = '0;
        end
    endtask

    task automatic add_write(int e, bit ch, logic [DW-1:0] v);
        wr_en[e]  = 1'b1;
        wr_ch[e]  = ch;
        wr_dat[e] = v;
    endtask

    // Called at a negedge with rst low; releases reset and runs ncyc edges.
    task automatic run_phase(int ncyc);
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 2; c++)
                for (int n = 0; n < 20; n++) rxw[i][c][n] = '0;
        drive(1);
        rst = 1'b1;
        check_cycle(0);
        for (int e = 1; e <= ncyc; e++) begin
            @(negedge clk);
            check_cycle(e);
            drive(e + 1);
        end
    endtask

    initial begin
        rst  = 1'b0;
        wr   = 1'b0;
        lr   = 1'b0;
        data = '0;
        repeat (3) @(negedge clk);
        chk_reset("rst_hold");

        // Edges are in SCLK_DIV=2 terms: left loads at 128n+4, right at 128n+68.
        clear_writes();
        add_write(1,   1'b0, 16'hA5C3);
        add_write(2,   1'b1, 16'h1234);
        add_write(200, 1'b0, 16'h0001);
        add_write(210, 1'b0, 16'h8000);
        add_write(220, 1'b1, 16'h0F0F);
        add_write(324, 1'b1, 16'hBEEF);
        gen_random(460, 1050, 4);
        // Ends right after the falling event at slot 7 of the SCLK_DIV=2 frame.
        run_phase(1057);

        rst = 1'b0;
        #1;
        chk_reset("rst_abort");

        chk("word_l0",  0, 32'(rxw[0][0][0]), 32'h0000A5C3);
        chk("word_r0",  0, 32'(rxw[0][1][0]), 32'h00001234);
        chk("word_l1",  0, 32'(rxw[0][0][1]), 32'h00000000);
        chk("word_r1",  0, 32'(rxw[0][1][1]), 32'h00000000);
        chk("word_l2",  0, 32'(rxw[0][0][2]), 32'h00008000);
        chk("word_r2",  0, 32'(rxw[0][1][2]), 32'h00000F0F);
        chk("word_r3",  0, 32'(rxw[0][1][3]), 32'h0000BEEF);
        chk("loop_l0",  1, 32'(rxw[1][0][0]), 32'h0000A5C3);
        chk("loop_r0",  1, 32'(rxw[1][1][0]), 32'h00001234);
        chk("loop_l0",  2, 32'(rxw[2][0][0]), 32'h0000A5C3);
        chk("loop_r0",  2, 32'(rxw[2][1][0]), 32'h00001234);

        repeat (2) begin
            @(negedge clk);
            chk_reset("rst_low");
        end

        clear_writes();
        gen_random(1, 300, 5);
        run_phase(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
